pc_seq: RTL and testbench

- Parametrised program-counter sequencer for the FEC processor fetch stage.
- Generalises the current PC in four ways: configurable address and offset widths, a start/run/done state machine, absolute jumps, and a hardware call/return stack.
- Drives the instruction-memory address and reports run status to the top-level controller.

---
 rtl/pc_seq_pkg.sv | 34 +++
 rtl/pc_ret_stack.sv | 50 +++++
 rtl/pc_seq.sv | 170 +++++++++++++++++
 tb/tb_pc_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
//   state_e  : IDLE / RUN / DONE sequencer states
//   action_e : per-cycle action chosen in RUN, highest priority first
//   sext32   : sign-extend the low w bits of a 32-bit value
package pc_seq_pkg;

  localparam int unsigned A_DEF     = 10;
  localparam int unsigned OFF_W_DEF = 8;
  localparam int unsigned STK_D_DEF = 4;
  localparam int unsigned CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    HALT   = 3'd0,
    RET    = 3'd1,
    CALL   = 3'd2,
    JUMP   = 3'd3,
    BRANCH = 3'd4,
    INC    = 3'd5
  } action_e;

  // Move bit w-1 to the top, then arithmetic-shift back down.
  function automatic logic [31:0] sext32(input logic [31:0] v, input int unsigned w);
    logic [31:0] sh;
    sh = v << (32 - w);
    return 32'($signed(sh) >>> (32 - w));
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address LIFO, STK_D entries of A bits.
//   push/din   : write din on top (ignored when full)
//   pop/dout   : dout always shows the top entry; pop discards it (ignored when empty)
//   clear      : empty the stack (wins over push/pop)
//   full/empty : occupancy flags
module pc_ret_stack #(
  parameter int unsigned A     = 10,
  parameter int unsigned STK_D = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [A-1:0] din,
  output logic [A-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW    = $clog2(STK_D + 1);
  // Storage rounded up to 2**PW so the pointer indexes it without width games;
  // slots at or above STK_D are never written and reduce to constants.
  localparam int unsigned NSLOT = 1 << PW;

  logic [PW-1:0] r_ptr;
  logic [A-1:0]  r_mem [NSLOT];
  logic [PW-1:0] w_top;

  assign w_top = r_ptr - PW'(1);
  assign dout  = r_mem[w_top];
  assign full  = (r_ptr == PW'(STK_D));
  assign empty = (r_ptr == '0);

  // Pointer and storage update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
      for (int i = 0; i < int'(NSLOT); i++) r_mem[i] <= '0;
    end else if (clear) begin
      r_ptr <= '0;
    end else if (push && !full) begin
      r_mem[r_ptr] <= din;
      r_ptr        <= r_ptr + PW'(1);
    end else if (pop && !empty) begin
      r_ptr <= w_top;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer for the fetch stage.
//   start/entry_addr : a program launches on start falling (1 then 0) from IDLE/DONE
//   stall            : freeze everything while running
//   branch/jump/call/ret/halt controls, one action per cycle in priority order
//   pc               : fetch address (registered)
//   running/done     : registered state decode
//   prog_count       : saturating count of completed programs
//   stk_ovf/stk_unf  : sticky stack overflow / underflow, cleared on launch
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int unsigned A     = A_DEF,
  parameter int unsigned OFF_W = OFF_W_DEF,
  parameter int unsigned STK_D = STK_D_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [A-1:0]     entry_addr,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             alu_en,
  input  logic [OFF_W-1:0] offset,
  input  logic             jump_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [A-1:0]     jump_addr,
  input  logic             halt_en,
  output logic [A-1:0]     pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] prog_count,
  output logic             stk_ovf,
  output logic             stk_unf
);

  state_e           r_state;
  logic [A-1:0]     r_pc;
  logic             r_start_q;
  logic             r_running;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_unf;

  state_e           w_state_nxt;
  logic [A-1:0]     w_pc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;
  action_e          w_act;
  logic             w_launch;
  logic [A-1:0]     w_pc_inc;
  logic [A-1:0]     w_off_ext;
  logic             w_push;
  logic             w_pop;
  logic             w_clear;
  logic [A-1:0]     w_top;
  logic             w_full;
  logic             w_empty;

  assign w_launch  = r_start_q & ~start;
  assign w_pc_inc  = r_pc + A'(1);
  assign w_off_ext = A'(sext32(32'(offset), OFF_W));

  pc_ret_stack #(.A(A), .STK_D(STK_D)) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .clear   (w_clear),
    .din     (w_pc_inc),
    .dout    (w_top),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Priority encode the run-time controls.
  always_comb begin
    w_act = INC;
    if (halt_en)                    w_act = HALT;
    else if (ret_en)                w_act = RET;
    else if (call_en)               w_act = CALL;
    else if (jump_en)               w_act = JUMP;
    else if (branch_en && alu_en)   w_act = BRANCH;
  end

  // Next-state, next-pc and stack control.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (w_launch) begin
          w_state_nxt = RUN;
          w_pc_nxt    = entry_addr;
          w_clear     = 1'b1;
          w_ovf_nxt   = 1'b0;
          w_unf_nxt   = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          case (w_act)
            HALT: begin
              w_state_nxt = DONE;
              if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            RET: begin
              if (!w_empty) begin
                w_pop    = 1'b1;
                w_pc_nxt = w_top;
              end else begin
                w_unf_nxt = 1'b1;
                w_pc_nxt  = w_pc_inc;
              end
            end
            CALL: begin
              w_pc_nxt = jump_addr;
              if (!w_full) w_push    = 1'b1;
              else         w_ovf_nxt = 1'b1;
            end
            JUMP:    w_pc_nxt = jump_addr;
            BRANCH:  w_pc_nxt = r_pc + w_off_ext;
            default: w_pc_nxt = w_pc_inc;
          endcase
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_start_q <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_start_q <= start;
      r_running <= (w_state_nxt == RUN);
      r_done    <= (w_state_nxt == DONE);
      r_cnt     <= w_cnt_nxt;
      r_ovf     <= w_ovf_nxt;
      r_unf     <= w_unf_nxt;
    end
  end

  assign pc         = r_pc;
  assign running    = r_running;
  assign done       = r_done;
  assign prog_count = r_cnt;
  assign stk_ovf    = r_ovf;
  assign stk_unf    = r_unf;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq (A=10, OFF_W=8, STK_D=4, CNT_W=4).
module tb_pc_seq;

  typedef struct {
    string      nm;
    logic       start;
    logic [9:0] entry;
    logic       stall;
    logic       br;
    logic       alu;
    logic [7:0] off;
    logic       jmp;
    logic       call;
    logic       ret;
    logic [9:0] jaddr;
    logic       halt;
    logic [9:0] e_pc;
    logic       e_run;
    logic       e_done;
    logic [3:0] e_cnt;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [9:0] entry_addr;
  logic       stall;
  logic       branch_en;
  logic       alu_en;
  logic [7:0] offset;
  logic       jump_en;
  logic       call_en;
  logic       ret_en;
  logic [9:0] jump_addr;
  logic       halt_en;
  logic [9:0] pc;
  logic       running;
  logic       done;
  logic [3:0] prog_count;
  logic       stk_ovf;
  logic       stk_unf;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t sb[$];
  vec_t tbl[$];

  pc_seq #(.A(10), .OFF_W(8), .STK_D(4), .CNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .entry_addr (entry_addr),
    .stall      (stall),
    .branch_en  (branch_en),
    .alu_en     (alu_en),
    .offset     (offset),
    .jump_en    (jump_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .jump_addr  (jump_addr),
    .halt_en    (halt_en),
    .pc         (pc),
    .running    (running),
    .done       (done),
    .prog_count (prog_count),
    .stk_ovf    (stk_ovf),
    .stk_unf    (stk_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t nv(string nm, logic [9:0] epc, logic erun, logic edn,
                              logic [3:0] ecnt, logic eovf, logic eunf);
    vec_t t;
    t.nm = nm; t.start = 1'b0; t.entry = '0; t.stall = 1'b0; t.br = 1'b0;
    t.alu = 1'b0; t.off = '0; t.jmp = 1'b0; t.call = 1'b0; t.ret = 1'b0;
    t.jaddr = '0; t.halt = 1'b0;
    t.e_pc = epc; t.e_run = erun; t.e_done = edn; t.e_cnt = ecnt;
    t.e_ovf = eovf; t.e_unf = eunf;
    return t;
  endfunction

  task automatic compare(input vec_t e);
    n_vec++;
    if (pc !== e.e_pc || running !== e.e_run || done !== e.e_done ||
        prog_count !== e.e_cnt || stk_ovf !== e.e_ovf || stk_unf !== e.e_unf) begin
      n_bad++;
      $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d ovf=%b unf=%b, want pc=%h run=%b done=%b cnt=%0d ovf=%b unf=%b",
               e.nm, pc, running, done, prog_count, stk_ovf, stk_unf,
               e.e_pc, e.e_run, e.e_done, e.e_cnt, e.e_ovf, e.e_unf);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    start = v.start; entry_addr = v.entry; stall = v.stall; branch_en = v.br;
    alu_en = v.alu; offset = v.off; jump_en = v.jmp; call_en = v.call;
    ret_en = v.ret; jump_addr = v.jaddr; halt_en = v.halt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard: queue empty, got pc=%h want an entry", pc);
    end else begin
      e = sb.pop_front();
      compare(e);
    end
  endtask

  initial begin
    vec_t t;
    int   cnt;
    int   ppc;
    int   punf;

    reset_n = 1'b0; start = 1'b0; entry_addr = '0; stall = 1'b0;
    branch_en = 1'b0; alu_en = 1'b0; offset = '0; jump_en = 1'b0;
    call_en = 1'b0; ret_en = 1'b0; jump_addr = '0; halt_en = 1'b0;

    // Main table: each row is one cycle of inputs and the outputs after that edge.
    for (int i = 0; i < 5; i++) tbl.push_back(nv("idle", 10'h000, 0, 0, 0, 0, 0));
    t = nv("arm1", 10'h000, 0, 0, 0, 0, 0); t.start = 1; t.entry = 10'h040; tbl.push_back(t);
    t = nv("arm2", 10'h000, 0, 0, 0, 0, 0); t.start = 1; t.entry = 10'h040; tbl.push_back(t);
    t = nv("launch", 10'h040, 1, 0, 0, 0, 0); t.entry = 10'h040; tbl.push_back(t);
    tbl.push_back(nv("inc1", 10'h041, 1, 0, 0, 0, 0));
    tbl.push_back(nv("inc2", 10'h042, 1, 0, 0, 0, 0));
    tbl.push_back(nv("inc3", 10'h043, 1, 0, 0, 0, 0));
    t = nv("br_taken", 10'h041, 1, 0, 0, 0, 0); t.br = 1; t.alu = 1; t.off = 8'hFE; tbl.push_back(t);
    t = nv("br_not", 10'h042, 1, 0, 0, 0, 0); t.br = 1; t.off = 8'hFE; tbl.push_back(t);
    t = nv("jmp_top", 10'h3FF, 1, 0, 0, 0, 0); t.jmp = 1; t.jaddr = 10'h3FF; tbl.push_back(t);
    tbl.push_back(nv("inc_wrap", 10'h000, 1, 0, 0, 0, 0));
    t = nv("br_neg_wrap", 10'h3FE, 1, 0, 0, 0, 0); t.br = 1; t.alu = 1; t.off = 8'hFE; tbl.push_back(t);
    t = nv("br_pos_wrap", 10'h07D, 1, 0, 0, 0, 0); t.br = 1; t.alu = 1; t.off = 8'h7F; tbl.push_back(t);
    t = nv("jmp_010", 10'h010, 1, 0, 0, 0, 0); t.jmp = 1; t.jaddr = 10'h010; tbl.push_back(t);
    t = nv("call_100", 10'h100, 1, 0, 0, 0, 0); t.call = 1; t.jaddr = 10'h100; tbl.push_back(t);
    t = nv("ret_011", 10'h011, 1, 0, 0, 0, 0); t.ret = 1; tbl.push_back(t);
    t = nv("call_n1", 10'h200, 1, 0, 0, 0, 0); t.call = 1; t.jaddr = 10'h200; tbl.push_back(t);
    t = nv("call_n2", 10'h210, 1, 0, 0, 0, 0); t.call = 1; t.jaddr = 10'h210; tbl.push_back(t);
    t = nv("call_n3", 10'h220, 1, 0, 0, 0, 0); t.call = 1; t.jaddr = 10'h220; tbl.push_back(t);
    t = nv("call_n4", 10'h230, 1, 0, 0, 0, 0); t.call = 1; t.jaddr = 10'h230; tbl.push_back(t);
    t = nv("call_ovf", 10'h240, 1, 0, 0, 1, 0); t.call = 1; t.jaddr = 10'h240; tbl.push_back(t);
    t = nv("ret_n4", 10'h221, 1, 0, 0, 1, 0); t.ret = 1; tbl.push_back(t);
    t = nv("ret_beats_call", 10'h211, 1, 0, 0, 1, 0); t.ret = 1; t.call = 1; t.jaddr = 10'h300; tbl.push_back(t);
    t = nv("ret_n2", 10'h201, 1, 0, 0, 1, 0); t.ret = 1; tbl.push_back(t);
    t = nv("ret_n1", 10'h012, 1, 0, 0, 1, 0); t.ret = 1; tbl.push_back(t);
    t = nv("ret_unf", 10'h013, 1, 0, 0, 1, 1); t.ret = 1; tbl.push_back(t);
    t = nv("stall_jmp", 10'h013, 1, 0, 0, 1, 1); t.stall = 1; t.jmp = 1; t.jaddr = 10'h3FF; tbl.push_back(t);
    t = nv("stall_halt", 10'h013, 1, 0, 0, 1, 1); t.stall = 1; t.halt = 1; tbl.push_back(t);
    t = nv("jmp_3ff", 10'h3FF, 1, 0, 0, 1, 1); t.jmp = 1; t.jaddr = 10'h3FF; tbl.push_back(t);
    t = nv("call_wrap", 10'h050, 1, 0, 0, 1, 1); t.call = 1; t.jaddr = 10'h050; tbl.push_back(t);
    t = nv("ret_wrap", 10'h000, 1, 0, 0, 1, 1); t.ret = 1; tbl.push_back(t);
    t = nv("run_start_hi", 10'h001, 1, 0, 0, 1, 1); t.start = 1; t.entry = 10'h300; tbl.push_back(t);
    t = nv("run_start_fall", 10'h060, 1, 0, 0, 1, 1); t.entry = 10'h300; t.call = 1; t.jaddr = 10'h060; tbl.push_back(t);
    t = nv("halt1", 10'h060, 0, 1, 1, 1, 1); t.halt = 1; t.jmp = 1; t.jaddr = 10'h123; tbl.push_back(t);
    t = nv("done_hold", 10'h060, 0, 1, 1, 1, 1); t.jmp = 1; t.jaddr = 10'h123; tbl.push_back(t);
    t = nv("done_arm_stall", 10'h060, 0, 1, 1, 1, 1); t.stall = 1; t.start = 1; t.entry = 10'h080; tbl.push_back(t);
    t = nv("relaunch_stall", 10'h080, 1, 0, 1, 0, 0); t.stall = 1; t.entry = 10'h080; tbl.push_back(t);
    t = nv("ret_after_clear", 10'h081, 1, 0, 1, 0, 1); t.ret = 1; tbl.push_back(t);
    t = nv("halt2", 10'h081, 0, 1, 2, 0, 1); t.halt = 1; tbl.push_back(t);

    #12;
    reset_n = 1'b1;
    #1;
    compare(nv("reset", 10'h000, 0, 0, 0, 0, 0));

    foreach (tbl[i]) step(tbl[i]);

    // Repeated launch/halt: prog_count saturates at 15.
    cnt = 2; ppc = 10'h081; punf = 1;
    for (int i = 0; i < 14; i++) begin
      t = nv("sat_arm", 10'(ppc), 0, 1, 4'(cnt), 0, 1'(punf)); t.start = 1; t.entry = 10'h100; step(t);
      t = nv("sat_go", 10'h100, 1, 0, 4'(cnt), 0, 0); t.entry = 10'h100; step(t);
      cnt = (cnt < 15) ? cnt + 1 : 15;
      t = nv("sat_halt", 10'h100, 0, 1, 4'(cnt), 0, 0); t.halt = 1; step(t);
      ppc = 10'h100; punf = 0;
    end

    // Launch at 0x123 then pulse reset asynchronously mid-run.
    t = nv("arm_123", 10'h100, 0, 1, 15, 0, 0); t.start = 1; t.entry = 10'h123; step(t);
    t = nv("go_123", 10'h123, 1, 0, 15, 0, 0); t.entry = 10'h123; step(t);
    #3;
    reset_n = 1'b0;
    #1;
    compare(nv("async_reset", 10'h000, 0, 0, 0, 0, 0));
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(nv("post_reset_idle", 10'h000, 0, 0, 0, 0, 0));

    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
